// File: rtl/pc_pkg.sv
// Shared command encoding for the program counter and the control sequencer.
// decode_cmd resolves simultaneous control strobes to a single command.
package pc_pkg;

   typedef enum logic [2:0] {
      CMD_HOLD = 3'd0,
      CMD_CP   = 3'd1,
      CMD_LP   = 3'd2,
      CMD_CALL = 3'd3,
      CMD_RET  = 3'd4,
      CMD_CLR  = 3'd5
   } cmd_e;

   // Fixed priority: clr > ret > call > lp > cp > hold.
   function automatic cmd_e decode_cmd(
      input logic clr,
      input logic ret,
      input logic call,
      input logic lp,
      input logic cp
   );
      cmd_e cmd;
      if (clr)       cmd = CMD_CLR;
      else if (ret)  cmd = CMD_RET;
      else if (call) cmd = CMD_CALL;
      else if (lp)   cmd = CMD_LP;
      else if (cp)   cmd = CMD_CP;
      else           cmd = CMD_HOLD;
      return cmd;
   endfunction

endpackage

// File: rtl/lifo_stack.sv
// Generic register-array LIFO. Pushes when full and pops when empty are dropped;
// the top entry is visible combinationally for zero-latency pops.
module lifo_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           push_data,
   output logic [WIDTH-1:0]           top_data,
   output logic [$clog2(DEPTH):0]     depth,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;
   localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);
   localparam logic [DW-1:0] ONE_CNT  = DW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [DW-1:0]    r_depth;
   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_top_idx;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign full      = (r_depth == FULL_CNT);
   assign empty     = (r_depth == '0);
   assign depth     = r_depth;
   assign w_push_ok = push && !full;
   assign w_pop_ok  = pop && !empty && !push;
   assign w_wr_idx  = r_depth[AW-1:0];
   // When full the low bits wrap to zero, so minus one still lands on the top slot.
   assign w_top_idx = r_depth[AW-1:0] - AW'(1);
   assign top_data  = r_mem[w_top_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_depth <= '0;
      end else if (clr) begin
         r_depth <= '0;
      end else if (w_push_ok) begin
         r_depth <= r_depth + ONE_CNT;
      end else if (w_pop_ok) begin
         r_depth <= r_depth - ONE_CNT;
      end
   end

   // Contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (!clr && w_push_ok) begin
         r_mem[w_wr_idx] <= push_data;
      end
   end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with load/count/bus drive plus call/return through a hardware
// return-address stack; wrap pulses on a rolling increment, err latches stack misuse.
module pc_call_stack
   import pc_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     lp,
   input  logic                     cp,
   input  logic                     call,
   input  logic                     ret,
   input  logic                     ep,
   input  logic [WIDTH-1:0]         bus_in,
   output logic [WIDTH-1:0]         bus_out,
   output logic [WIDTH-1:0]         bus_oe,
   output logic [WIDTH-1:0]         pc,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     full,
   output logic                     empty,
   output logic                     wrap,
   output logic                     err
);

   localparam logic [WIDTH-1:0] PC_ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_pc;
   logic             r_wrap;
   logic             r_err;
   cmd_e             w_cmd;
   logic [WIDTH-1:0] w_pc_inc;
   logic [WIDTH-1:0] w_top;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;

   assign w_cmd    = decode_cmd(clr, ret, call, lp, cp);
   assign w_pc_inc = r_pc + PC_ONE;
   assign w_push   = (w_cmd == CMD_CALL) && !w_full;
   assign w_pop    = (w_cmd == CMD_RET) && !w_empty;

   lifo_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (w_cmd == CMD_CLR),
      .push      (w_push),
      .pop       (w_pop),
      .push_data (w_pc_inc),
      .top_data  (w_top),
      .depth     (depth),
      .full      (w_full),
      .empty     (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc   <= RESET_VEC;
         r_wrap <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         case (w_cmd)
            CMD_CLR: begin
               r_pc  <= RESET_VEC;
               r_err <= 1'b0;
            end
            CMD_RET: begin
               if (w_empty) r_err <= 1'b1;
               else         r_pc  <= w_top;
            end
            // A call on a full stack is rejected outright: no push, no jump.
            CMD_CALL: begin
               if (w_full) r_err <= 1'b1;
               else        r_pc  <= bus_in;
            end
            CMD_LP: r_pc <= bus_in;
            CMD_CP: begin
               r_pc   <= w_pc_inc;
               r_wrap <= &r_pc;
            end
            default: ;
         endcase
      end
   end

   assign pc      = r_pc;
   assign wrap    = r_wrap;
   assign err     = r_err;
   assign full    = w_full;
   assign empty   = w_empty;
   assign bus_out = r_pc;
   assign bus_oe  = {WIDTH{ep}};

endmodule
